dma_read_scheduler: RTL and testbench

Command sequencer directly upstream of the DMA read control block. It accepts one read job: base address, total byte count and maximum chunk size. It splits the job into successive DMA read commands, driving `dma_sa_config`, `dma_length_config` and a one-cycle `dma_read_valid` whenever the DMA reports idle. For each chunk it waits for the DMA completion interrupt before issuing the next, and signals job completion or error to the controlling logic.

---
 rtl/dma_sched_pkg.sv | 9 +
 rtl/dma_read_scheduler.sv | 153 +++++++++++++++
 tb/tb_dma_read_scheduler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dma_sched_pkg.sv
// Shared types and default widths for the DMA read scheduler.
package dma_sched_pkg;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 26;
  localparam int CNT_W  = 16;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_DONE, FINISH} state_t;
endpackage

// File: rtl/dma_read_scheduler.sv
// Splits one read job into chunked DMA read commands, one outstanding at a time.
//
// state     | meaning
// IDLE      | waiting for job_start, job parameters latched on accept
// CHECK     | validating alignment, zero sizes and address range
// ISSUE     | command pending, held off while the DMA is busy
// WAIT_DONE | command in flight, waiting for dma_irq
// FINISH    | job_done (and job_err) pulse cycle
module dma_read_scheduler #(
  parameter int ADDR_W = dma_sched_pkg::ADDR_W,
  parameter int LEN_W  = dma_sched_pkg::LEN_W,
  parameter int CNT_W  = dma_sched_pkg::CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              job_start,
  input  logic [ADDR_W-1:0] job_base,
  input  logic [31:0]       job_total,
  input  logic [LEN_W-1:0]  job_chunk,
  input  logic              job_abort,
  output logic              job_busy,
  output logic              job_done,
  output logic              job_err,
  input  logic              dma_idle,
  input  logic              dma_irq,
  output logic              dma_read_valid,
  output logic [ADDR_W-1:0] dma_sa_config,
  output logic [LEN_W-1:0]  dma_length_config,
  output logic [CNT_W-1:0]  chunk_count
);
  import dma_sched_pkg::*;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_r, addr_n;
  logic [31:0]         rem_r, rem_n;
  logic [LEN_W-1:0]    chunk_r, chunk_n;
  logic [CNT_W-1:0]    cnt_n;
  logic                abort_r, abort_n, abort_eff;
  logic                issue, err_n, bad;
  logic [ADDR_W:0]     sum_w;
  logic [31:0]         min32;
  logic [LEN_W-1:0]    len_sel;

  assign abort_eff = abort_r | job_abort;
  assign sum_w     = (ADDR_W+1)'(addr_r) + (ADDR_W+1)'(rem_r);
  assign bad = (chunk_r == '0) || (rem_r == '0)
            || ((addr_r[1:0] & ALIGN_MASK) != 2'b00)
            || ((rem_r[1:0] & ALIGN_MASK) != 2'b00)
            || ((chunk_r[1:0] & ALIGN_MASK) != 2'b00)
            || (sum_w[ADDR_W] && (sum_w[ADDR_W-1:0] != '0));

  // Issuing is decided one edge early so the registered strobe lands in the
  // cycle right after CHECK passes or right after the previous dma_irq.
  always_comb begin
    state_n = state;
    addr_n  = addr_r;
    rem_n   = rem_r;
    chunk_n = chunk_r;
    cnt_n   = chunk_count;
    abort_n = abort_r;
    issue   = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        abort_n = 1'b0;
        if (job_start) begin
          addr_n  = job_base;
          rem_n   = job_total;
          chunk_n = job_chunk;
          cnt_n   = '0;
          state_n = CHECK;
        end
      end
      CHECK: begin
        abort_n = abort_eff;
        if (bad || abort_eff) begin
          state_n = FINISH;
          err_n   = 1'b1;
        end else if (dma_idle) begin
          issue   = 1'b1;
          state_n = WAIT_DONE;
        end else begin
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        abort_n = abort_eff;
        if (abort_eff) begin
          state_n = FINISH;
          err_n   = 1'b1;
        end else if (dma_idle) begin
          issue   = 1'b1;
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        abort_n = abort_eff;
        if (dma_irq) begin
          addr_n = addr_r + ADDR_W'(dma_length_config);
          rem_n  = rem_r - 32'(dma_length_config);
          if (chunk_count != '1) cnt_n = chunk_count + CNT_W'(1);
          if (rem_n == '0) begin
            state_n = FINISH;
          end else if (abort_eff) begin
            state_n = FINISH;
            err_n   = 1'b1;
          end else if (dma_idle) begin
            issue   = 1'b1;
            state_n = WAIT_DONE;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    min32   = (32'(chunk_r) < rem_n) ? 32'(chunk_r) : rem_n;
    len_sel = LEN_W'(min32);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state             <= IDLE;
      addr_r            <= '0;
      rem_r             <= '0;
      chunk_r           <= '0;
      abort_r           <= 1'b0;
      chunk_count       <= '0;
      dma_read_valid    <= 1'b0;
      dma_sa_config     <= '0;
      dma_length_config <= '0;
      job_busy          <= 1'b0;
      job_done          <= 1'b0;
      job_err           <= 1'b0;
    end else begin
      state          <= state_n;
      addr_r         <= addr_n;
      rem_r          <= rem_n;
      chunk_r        <= chunk_n;
      abort_r        <= abort_n;
      chunk_count    <= cnt_n;
      dma_read_valid <= issue;
      if (issue) begin
        dma_sa_config     <= addr_n;
        dma_length_config <= len_sel;
      end
      job_busy <= (state_n != IDLE);
      job_done <= (state_n == FINISH);
      job_err  <= (state_n == FINISH) && err_n;
    end
  end
endmodule

// File: tb/tb_dma_read_scheduler.sv
// Directed bench for dma_read_scheduler: chunking, rejects, backpressure, abort, reset.
module tb_dma_read_scheduler;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        job_start = 1'b0;
  logic [31:0] job_base = '0;
  logic [31:0] job_total = '0;
  logic [25:0] job_chunk = '0;
  logic        job_abort = 1'b0;
  logic        job_busy, job_done, job_err;
  logic        dma_idle = 1'b1;
  logic        dma_irq = 1'b0;
  logic        dma_read_valid;
  logic [31:0] dma_sa_config;
  logic [25:0] dma_length_config;
  logic [15:0] chunk_count;

  int n_checks = 0;
  int n_fail   = 0;
  int strobes  = 0;
  int consec   = 0;
  int base_cnt;
  logic prev_valid = 1'b0;

  dma_read_scheduler dut (
    .CLK(CLK), .RST(RST),
    .job_start(job_start), .job_base(job_base), .job_total(job_total),
    .job_chunk(job_chunk), .job_abort(job_abort),
    .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
    .dma_idle(dma_idle), .dma_irq(dma_irq),
    .dma_read_valid(dma_read_valid), .dma_sa_config(dma_sa_config),
    .dma_length_config(dma_length_config), .chunk_count(chunk_count)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (dma_read_valid) strobes++;
    if (dma_read_valid && prev_valid) consec++;
    prev_valid = dma_read_valid;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] b, input logic [31:0] t, input logic [25:0] c);
    job_base  = b;
    job_total = t;
    job_chunk = c;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    chk("accept_busy", job_busy, 1);
  endtask

  task automatic wait_strobe(input string tag, input logic [31:0] sa, input logic [25:0] len);
    int k = 0;
    while (!dma_read_valid && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_seen"}, dma_read_valid, 1);
    chk({tag, "_sa"}, dma_sa_config, sa);
    chk({tag, "_len"}, dma_length_config, len);
  endtask

  task automatic do_chunk(input string tag, input logic [31:0] sa, input logic [25:0] len);
    wait_strobe(tag, sa, len);
    repeat (4) tick();
    dma_irq = 1'b1;
    tick();
    dma_irq = 1'b0;
  endtask

  task automatic reject_job(input string tag, input logic [31:0] b, input logic [31:0] t, input logic [25:0] c);
    base_cnt = strobes;
    start_job(b, t, c);
    chk({tag, "_check_done"}, job_done, 0);
    tick();
    chk({tag, "_done"}, job_done, 1);
    chk({tag, "_err"}, job_err, 1);
    chk({tag, "_cnt"}, chunk_count, 0);
    tick();
    chk({tag, "_idle"}, job_busy, 0);
    chk({tag, "_strobes"}, strobes - base_cnt, 0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_valid", dma_read_valid, 0);
    chk("rst_busy", job_busy, 0);
    chk("rst_done", job_done, 0);
    chk("rst_sa", dma_sa_config, 0);
    chk("rst_cnt", chunk_count, 0);
    RST = 1'b1;
    tick();

    // exact multiple
    base_cnt = strobes;
    start_job(32'h0, 32'h100, 26'h40);
    chk("ex_check_no_strobe", dma_read_valid, 0);
    tick();
    chk("ex_first_latency", dma_read_valid, 1);
    do_chunk("ex_c0", 32'h00, 26'h40);
    chk("ex_irq_to_strobe", dma_read_valid, 1);
    do_chunk("ex_c1", 32'h40, 26'h40);
    do_chunk("ex_c2", 32'h80, 26'h40);
    do_chunk("ex_c3", 32'hC0, 26'h40);
    chk("ex_done", job_done, 1);
    chk("ex_err", job_err, 0);
    chk("ex_cnt", chunk_count, 4);
    chk("ex_busy_still", job_busy, 1);
    tick();
    chk("ex_done_pulse", job_done, 0);
    chk("ex_busy_low", job_busy, 0);
    chk("ex_strobes", strobes - base_cnt, 4);
    chk("ex_sa_hold", dma_sa_config, 32'hC0);

    // remainder
    base_cnt = strobes;
    start_job(32'h1000, 32'h90, 26'h40);
    do_chunk("rm_c0", 32'h1000, 26'h40);
    do_chunk("rm_c1", 32'h1040, 26'h40);
    do_chunk("rm_c2", 32'h1080, 26'h10);
    chk("rm_done", job_done, 1);
    chk("rm_err", job_err, 0);
    chk("rm_cnt", chunk_count, 3);
    tick();
    chk("rm_strobes", strobes - base_cnt, 3);

    // rejects
    reject_job("rj_chunk0", 32'h0, 32'h100, 26'h0);
    reject_job("rj_base2", 32'h2, 32'h100, 26'h40);
    reject_job("rj_range", 32'hFFFF_FFC0, 32'h80, 26'h40);

    // backpressure, ignored job_start and stray irq
    base_cnt = strobes;
    dma_idle = 1'b0;
    start_job(32'h2000, 32'h80, 26'h40);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        job_base  = 32'h9000;
        job_total = 32'h4;
        job_start = 1'b1;
      end
      if (i == 6) dma_irq = 1'b1;
      tick();
      job_start = 1'b0;
      dma_irq   = 1'b0;
    end
    chk("bp_held", strobes - base_cnt, 0);
    dma_idle = 1'b1;
    tick();
    chk("bp_release", dma_read_valid, 1);
    do_chunk("bp_c0", 32'h2000, 26'h40);
    do_chunk("bp_c1", 32'h2040, 26'h40);
    chk("bp_done", job_done, 1);
    chk("bp_err", job_err, 0);
    chk("bp_cnt", chunk_count, 2);
    tick();

    // abort during chunk 2
    base_cnt = strobes;
    start_job(32'h3000, 32'h100, 26'h40);
    do_chunk("ab_c0", 32'h3000, 26'h40);
    wait_strobe("ab_c1", 32'h3040, 26'h40);
    tick();
    job_abort = 1'b1;
    tick();
    job_abort = 1'b0;
    repeat (2) tick();
    chk("ab_inflight_busy", job_busy, 1);
    dma_irq = 1'b1;
    tick();
    dma_irq = 1'b0;
    chk("ab_done", job_done, 1);
    chk("ab_err", job_err, 1);
    chk("ab_cnt", chunk_count, 2);
    repeat (3) tick();
    chk("ab_strobes", strobes - base_cnt, 2);
    chk("ab_idle", job_busy, 0);

    // reset mid-job
    start_job(32'h4000, 32'h100, 26'h40);
    do_chunk("rs_c0", 32'h4000, 26'h40);
    wait_strobe("rs_c1", 32'h4040, 26'h40);
    tick();
    RST = 1'b0;
    tick();
    chk("rs_valid", dma_read_valid, 0);
    chk("rs_sa", dma_sa_config, 0);
    chk("rs_len", dma_length_config, 0);
    chk("rs_busy", job_busy, 0);
    chk("rs_done", job_done, 0);
    chk("rs_err", job_err, 0);
    chk("rs_cnt", chunk_count, 0);
    RST = 1'b1;
    base_cnt = strobes;
    tick();
    dma_irq = 1'b1;
    tick();
    dma_irq = 1'b0;
    tick();
    chk("rs_irq_ignored_busy", job_busy, 0);
    chk("rs_irq_ignored_done", job_done, 0);
    chk("rs_irq_ignored_strobes", strobes - base_cnt, 0);
    start_job(32'h5000, 32'h40, 26'h40);
    do_chunk("rs_new", 32'h5000, 26'h40);
    chk("rs_new_done", job_done, 1);
    chk("rs_new_err", job_err, 0);
    chk("rs_new_cnt", chunk_count, 1);
    tick();

    chk("no_back_to_back", consec, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
